fetch_decode_reg: RTL

- IF/ID pipeline boundary register. Sits directly upstream of the decode-stage immediate extender and control decoder, and supplies their 32-bit InstrD.
- Captures instruction, PC and PC+4 from fetch.
- Supports stall (hold) and flush (bubble insertion).
- A one-entry skid buffer absorbs an instruction that the synchronous instruction memory returns while decode is stalled.

---
 rtl/fetch_decode_reg_pkg.sv | 30 +++
 rtl/fetch_decode_reg_skid_buffer.sv | 41 ++++
 rtl/fetch_decode_reg.sv | 67 ++++++
 3 files changed

// File: rtl/fetch_decode_reg_pkg.sv
// Shared IF/ID pipeline types and constants used by the fetch/decode boundary register.
package fetch_decode_reg_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;
    localparam logic [XLEN-1:0] RESET_PC  = '0;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    function automatic if_id_t bubble();
        if_id_t b;
        b.instr    = NOP_INSTR;
        b.pc       = RESET_PC;
        b.pc_plus4 = RESET_PC;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_decode_reg_skid_buffer.sv
// One-entry holding register: captures on load while empty, drains on unload or flush.
module skid_buffer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          load,
    input  logic          unload,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full
);
    import fetch_decode_reg_pkg::*;

    skid_state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SKID_EMPTY;
            dout  <= '0;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (!flush && load) begin
                        state <= SKID_FULL;
                        dout  <= din;
                    end
                end
                SKID_FULL: begin
                    if (flush || unload)
                        state <= SKID_EMPTY;
                end
                default: state <= SKID_EMPTY;
            endcase
        end
    end

    assign full = (state == SKID_FULL);

endmodule

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register with stall, flush and a one-entry skid for late imem returns.
module fetch_decode_reg #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  NOP_INSTR = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic [WIDTH-1:0] InstrF,
    input  logic [WIDTH-1:0] PCF,
    input  logic [WIDTH-1:0] PCPlus4F,
    input  logic             InstrValidF,
    output logic             ReadyF,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic             ValidD
);
    import fetch_decode_reg_pkg::*;

    if_id_t fetch_in;
    if_id_t skid_out;
    if_id_t d_q;
    logic   skid_full;

    always_comb begin
        fetch_in.instr    = InstrValidF ? InstrF : NOP_INSTR;
        fetch_in.pc       = PCF;
        fetch_in.pc_plus4 = PCPlus4F;
        fetch_in.valid    = InstrValidF;
    end

    // The skid only captures in the EMPTY state, so load needs no state qualifier here.
    skid_buffer #(
        .DW($bits(if_id_t))
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .flush  (FlushD),
        .load   (StallD && InstrValidF),
        .unload (!StallD),
        .din    (fetch_in),
        .dout   (skid_out),
        .full   (skid_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= bubble();
        end else if (FlushD) begin
            d_q <= bubble();
        end else if (!StallD) begin
            d_q <= skid_full ? skid_out : fetch_in;
        end
    end

    // Driven only by registered skid state so the hazard unit never reaches fetch combinationally.
    assign ReadyF   = ~skid_full;
    assign InstrD   = d_q.instr;
    assign PCD      = d_q.pc;
    assign PCPlus4D = d_q.pc_plus4;
    assign ValidD   = d_q.valid;

    no_fetch_while_busy: assert property (@(posedge clk) disable iff (rst) !(InstrValidF && !ReadyF));

endmodule
